// File: rtl/fp_addsub_scheduler.sv
// -----------------------------------------------------------------------------
// fp_addsub_scheduler
//
// Time-shares one combinational IEEE-754 single-precision adder between
// N_REQ requesters. Each requester asks for A+B or A-B; subtraction is
// realised by flipping the sign bit of B before it reaches the adder.
// Requesters are served round-robin, one operation at a time, through a
// three-state sequence IDLE -> EXEC -> RESP. The result is returned on a
// single tagged response channel with backpressure.
//
// Ports
//   clk, rst      : clock (rising edge) and synchronous active-high reset
//   req_valid     : per-requester request valid            [N_REQ]
//   req_ready     : per-requester accept, one-hot or zero  [N_REQ]
//   req_op        : per-requester op, 0 = A+B, 1 = A-B     [N_REQ]
//   req_a, req_b  : packed operands, requester i at [32i+31:32i]
//   resp_valid    : result valid
//   resp_ready    : consumer accepts result
//   resp_id       : index of the requester owning the result
//   resp_data     : result word (adder output, bit-exact)
//   fpu_a, fpu_b  : registered operands to the shared adder (B sign-adjusted)
//   fpu_sum       : combinational sum from the shared adder
//   busy          : high whenever the sequencer is not idle
//   op_count      : completed response handshakes, wraps modulo 2**CNT_W
// -----------------------------------------------------------------------------
module fp_addsub_scheduler #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ-1:0]     req_op,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [31:0]          resp_data,
    output logic [31:0]          fpu_a,
    output logic [31:0]          fpu_b,
    input  logic [31:0]          fpu_sum,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    id_q;
    logic [31:0]        op_a_q;
    logic [31:0]        op_b_q;
    logic               resp_valid_q;
    logic [ID_W-1:0]    resp_id_q;
    logic [31:0]        resp_data_q;
    logic [CNT_W-1:0]   op_count_q;

    logic               grant_found_s;
    logic [ID_W-1:0]    grant_idx_s;
    logic [ID_W-1:0]    rr_next_s;
    logic [31:0]        sel_a_s;
    logic [31:0]        sel_b_s;
    logic               sel_op_s;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int  idx_v;
        logic hit_v;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        idx_v         = 0;
        hit_v         = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_v = int'(rr_ptr_q) + k;
            idx_v = (idx_v >= N_REQ) ? (idx_v - N_REQ) : idx_v;
            hit_v = !grant_found_s && req_valid[idx_v];
            grant_idx_s   = hit_v ? ID_W'(idx_v) : grant_idx_s;
            grant_found_s = grant_found_s | hit_v;
        end
    end

    // Operand selection for the granted requester and the pointer advance.
    always_comb begin
        sel_a_s   = req_a[32*grant_idx_s +: 32];
        sel_b_s   = req_b[32*grant_idx_s +: 32];
        sel_op_s  = req_op[grant_idx_s];
        rr_next_s = (grant_idx_s == ID_W'(N_REQ - 1)) ? '0 : (grant_idx_s + ID_W'(1));
    end

    // Next-state logic and the combinational one-cycle accept pulse.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        case (state_q)
            S_IDLE: begin
                // Accept is suppressed during reset so no requester sees a
                // handshake that the reset edge will discard.
                if (grant_found_s && !rst) begin
                    state_d   = S_EXEC;
                    req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_EXEC: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_valid_q && resp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, operand, response and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            op_a_q       <= 32'h0000_0000;
            op_b_q       <= 32'h0000_0000;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= 32'h0000_0000;
            op_count_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (grant_found_s) begin
                        op_a_q   <= sel_a_s;
                        // Subtract by negating B: flip only the sign bit.
                        op_b_q   <= {sel_b_s[31] ^ sel_op_s, sel_b_s[30:0]};
                        id_q     <= grant_idx_s;
                        rr_ptr_q <= rr_next_s;
                    end
                end
                S_EXEC: begin
                    resp_data_q  <= fpu_sum;
                    resp_id_q    <= id_q;
                    resp_valid_q <= 1'b1;
                end
                S_RESP: begin
                    if (resp_valid_q && resp_ready) begin
                        resp_valid_q <= 1'b0;
                        op_count_q   <= op_count_q + CNT_W'(1);
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign fpu_a      = op_a_q;
    assign fpu_b      = op_b_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign op_count   = op_count_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_addsub_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fp_addsub_scheduler
//
// Directed bench for fp_addsub_scheduler (N_REQ=4, ID_W=2, CNT_W=2 so the
// counter wrap is reachable). The shared adder is stood in for by a lookup
// of hand-computed single-precision sums for the operand pairs used here.
// Inputs are driven shortly after the rising edge and outputs are sampled
// 1 ns after that, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_fp_addsub_scheduler;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 2;

    logic                 clk;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ-1:0]     req_op;
    logic [32*N_REQ-1:0]  req_a;
    logic [32*N_REQ-1:0]  req_b;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [ID_W-1:0]      resp_id;
    logic [31:0]          resp_data;
    logic [31:0]          fpu_a;
    logic [31:0]          fpu_b;
    logic [31:0]          fpu_sum;
    logic                 busy;
    logic [CNT_W-1:0]     op_count;

    int chk_total;
    int chk_pass;
    int exp_cnt;

    fp_addsub_scheduler #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .fpu_a      (fpu_a),
        .fpu_b      (fpu_b),
        .fpu_sum    (fpu_sum),
        .busy       (busy),
        .op_count   (op_count)
    );

    // Clock generation, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Adder stand-in: known sums for the operand pairs used by this bench.
    always_comb begin
        case ({fpu_a, fpu_b})
            {32'h3F80_0000, 32'h3F80_0000}: fpu_sum = 32'h4000_0000; // 1 + 1
            {32'h4040_0000, 32'hBF80_0000}: fpu_sum = 32'h4000_0000; // 3 + -1
            {32'h3F80_0000, 32'h4000_0000}: fpu_sum = 32'h4040_0000; // 1 + 2
            {32'h3F80_0000, 32'h4040_0000}: fpu_sum = 32'h4080_0000; // 1 + 3
            {32'h3F80_0000, 32'h4080_0000}: fpu_sum = 32'h40A0_0000; // 1 + 4
            default:                        fpu_sum = fpu_a ^ fpu_b;
        endcase
    end

    // Safety net against a hung run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 100000 ns");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_total++;
        if (obs === exp) begin
            chk_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_req_ready"},  32'(req_ready),  32'h0);
        check_val({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
        check_val({tag, "_resp_id"},    32'(resp_id),    32'h0);
        check_val({tag, "_resp_data"},  resp_data,       32'h0);
        check_val({tag, "_fpu_a"},      fpu_a,           32'h0);
        check_val({tag, "_fpu_b"},      fpu_b,           32'h0);
        check_val({tag, "_busy"},       32'(busy),       32'h0);
        check_val({tag, "_op_count"},   32'(op_count),   32'h0);
    endtask

    initial begin
        logic [31:0] rr_b   [4];
        logic [31:0] rr_sum [4];
        rr_b[0]   = 32'h3F80_0000; rr_sum[0] = 32'h4000_0000;
        rr_b[1]   = 32'h4000_0000; rr_sum[1] = 32'h4040_0000;
        rr_b[2]   = 32'h4040_0000; rr_sum[2] = 32'h4080_0000;
        rr_b[3]   = 32'h4080_0000; rr_sum[3] = 32'h40A0_0000;

        chk_total  = 0;
        chk_pass   = 0;
        exp_cnt    = 0;
        rst        = 1'b1;
        req_valid  = '0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;

        step();
        step();
        rst = 1'b0;
        #1;
        check_reset_outputs("reset");

        // ---- Add: requester 0, 1.0 + 1.0 ----
        req_valid      = 4'b0001;
        req_a[31:0]    = 32'h3F80_0000;
        req_b[31:0]    = 32'h3F80_0000;
        resp_ready     = 1'b1;
        #1;
        check_val("add_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        #1;
        check_val("add_exec_ready", 32'(req_ready),  32'h0);
        check_val("add_exec_busy",  32'(busy),       32'h1);
        check_val("add_exec_valid", 32'(resp_valid), 32'h0);
        check_val("add_fpu_a",      fpu_a,           32'h3F80_0000);
        check_val("add_fpu_b",      fpu_b,           32'h3F80_0000);
        step();
        check_val("add_resp_valid", 32'(resp_valid), 32'h1);
        check_val("add_resp_id",    32'(resp_id),    32'h0);
        check_val("add_resp_data",  resp_data,       32'h4000_0000);
        step();
        exp_cnt++;
        check_val("add_done_valid", 32'(resp_valid), 32'h0);
        check_val("add_op_count",   32'(op_count),   32'(exp_cnt % 4));
        check_val("add_done_busy",  32'(busy),       32'h0);

        // ---- Subtract: requester 2, 3.0 - 1.0 ----
        req_valid      = 4'b0100;
        req_op         = 4'b0100;
        req_a[95:64]   = 32'h4040_0000;
        req_b[95:64]   = 32'h3F80_0000;
        #1;
        check_val("sub_grant", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        req_op    = '0;
        #1;
        check_val("sub_fpu_a", fpu_a, 32'h4040_0000);
        check_val("sub_fpu_b", fpu_b, 32'hBF80_0000);
        step();
        check_val("sub_resp_data", resp_data,     32'h4000_0000);
        check_val("sub_resp_id",   32'(resp_id),  32'h2);
        step();
        exp_cnt++;
        check_val("sub_op_count", 32'(op_count), 32'(exp_cnt % 4));

        // ---- Backpressure: requester 1, 1.0 + 2.0, consumer stalls ----
        req_valid      = 4'b0010;
        req_a[63:32]   = 32'h3F80_0000;
        req_b[63:32]   = 32'h4000_0000;
        resp_ready     = 1'b0;
        #1;
        check_val("bp_grant", 32'(req_ready), 32'h2);
        step();
        check_val("bp_exec_ready", 32'(req_ready), 32'h0);
        step();
        check_val("bp_resp_valid", 32'(resp_valid), 32'h1);
        check_val("bp_resp_data",  resp_data,       32'h4040_0000);
        check_val("bp_resp_id",    32'(resp_id),    32'h1);
        for (int c = 0; c < 5; c++) begin
            step();
            check_val($sformatf("bp_hold%0d_valid", c), 32'(resp_valid), 32'h1);
            check_val($sformatf("bp_hold%0d_data", c),  resp_data,       32'h4040_0000);
            check_val($sformatf("bp_hold%0d_id", c),    32'(resp_id),    32'h1);
            check_val($sformatf("bp_hold%0d_ready", c), 32'(req_ready),  32'h0);
            check_val($sformatf("bp_hold%0d_busy", c),  32'(busy),       32'h1);
        end
        resp_ready = 1'b1;
        step();
        exp_cnt++;
        check_val("bp_released_valid", 32'(resp_valid), 32'h0);
        check_val("bp_op_count",       32'(op_count),   32'(exp_cnt % 4));
        // Requester 1 is still asking and wins the following IDLE cycle.
        check_val("bp_regrant",        32'(req_ready),  32'h2);

        // ---- Reset while in EXEC ----
        step();
        check_val("rst_in_exec_busy", 32'(busy), 32'h1);
        rst       = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        step();
        check_val("rst_mid_no_resp1", 32'(resp_valid), 32'h0);
        step();
        check_val("rst_mid_no_resp2", 32'(resp_valid), 32'h0);
        exp_cnt = 0;

        // ---- Round-robin with all valid, also drives the 2-bit counter wrap ----
        for (int i = 0; i < N_REQ; i++) begin
            req_a[32*i +: 32] = 32'h3F80_0000;
            req_b[32*i +: 32] = rr_b[i];
        end
        req_op     = '0;
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        #1;
        for (int n = 0; n < 5; n++) begin
            int g;
            g = n % N_REQ;
            check_val($sformatf("rr%0d_grant", n), 32'(req_ready), 32'(1 << g));
            step();
            check_val($sformatf("rr%0d_exec_ready", n), 32'(req_ready), 32'h0);
            check_val($sformatf("rr%0d_exec_busy", n),  32'(busy),      32'h1);
            step();
            check_val($sformatf("rr%0d_resp_id", n),   32'(resp_id),    32'(g));
            check_val($sformatf("rr%0d_resp_data", n), resp_data,       rr_sum[g]);
            check_val($sformatf("rr%0d_resp_valid", n), 32'(resp_valid), 32'h1);
            step();
            exp_cnt++;
            check_val($sformatf("rr%0d_op_count", n), 32'(op_count), 32'(exp_cnt % 4));
        end

        req_valid = '0;
        step();
        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
